vga_vram_arbiter: RTL
=====================

Name: vga_vram_arbiter

Overview:
- Shares one single-port, synchronous-read video RAM between the VGA display fetch and a pixel writer.
- The framebuffer is 160x120 at 3-bit colour; each stored pixel is shown as a 4x4 block on the 640x480 display.
- Sits between the 640x480@25 MHz timing generator (hcount/vcount/hsync/vsync) and the RGB pins.
- Also contains a clear engine that fills the framebuffer with one colour.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- FB_W, 160, framebuffer width (H_ACTIVE/4)
- FB_H, 120, framebuffer height (V_ACTIVE/4)
- ADDR_W, 15, RAM address width
- DEPTH, 19200, framebuffer words (FB_W*FB_H)
- PIPE, 3, display latency in cycles from hcount/vcount to RGB

Ports:
- CLK_25MH  in  1  25 MHz pixel clock
- RESET_N  in  1  asynchronous active-low reset
- hcount  in  10  horizontal position from the timing generator
- vcount  in  10  vertical position from the timing generator
- hsync_in  in  1  raw hsync
- vsync_in  in  1  raw vsync
- wr_req  in  1  write request; held until wr_ack
- wr_addr  in  ADDR_W  write word address, y*160+x
- wr_data  in  3  write colour
- wr_ack  out  1  one-cycle acknowledge
- clr_start  in  1  pulse: start a framebuffer clear
- clr_color  in  3  fill colour, sampled on clr_start
- clr_busy  out  1  high while clearing
- mem_addr  out  ADDR_W  RAM address
- mem_we  out  1  RAM write enable
- mem_wdata  out  3  RAM write data
- mem_rdata  in  3  RAM read data, valid the cycle after mem_addr is presented
- RGB  out  3  pixel colour
- hsync  out  1  hsync delayed by PIPE
- vsync  out  1  vsync delayed by PIPE

Behaviour:
- Reset values: mem_addr=0, mem_we=0, mem_wdata=0, wr_ack=0, clr_busy=0, RGB=0, hsync=1, vsync=1, pixel hold register=0, all pipeline flags=0, FSM=IDLE, clear counter=0.
- Reset asserted mid-clear aborts the clear with no further writes.
- All outputs are registered.

Slot classification (cycle t):
- active = hcount<H_ACTIVE && vcount<V_ACTIVE.
- fetch slot = active && hcount[1:0]==0; every other cycle is a free slot.

Display fetch path:
- In a fetch slot, mem_addr <= (vcount>>2)*160 + (hcount>>2), mem_we <= 0.
- Multiply implemented as shifts: x128 + x32.
- RAM returns data in cycle t+2. At edge t+3: RGB <= mem_rdata and hold <= mem_rdata.
- Non-fetch active cycles: RGB <= hold.
- Inactive cycles: RGB <= 0.
- hsync/vsync pass through a PIPE-deep shift register, so RGB, hsync and vsync stay mutually aligned.

Arbitration, free slots only:
- Priority: display > clear > writer.
- The writer never uses a fetch slot.

Clear FSM:
- IDLE: on clr_start, latch clr_color, counter=0, clr_busy=1, go to CLEAR.
- CLEAR: each free slot writes (counter, colour) and increments counter.
- After writing DEPTH-1, clr_busy=0 and return to IDLE.
- clr_start while in CLEAR is ignored.

Writer handshake:
- On a free slot with no clear granted and wr_req=1: mem_addr <= wr_addr, mem_wdata <= wr_data, mem_we <= 1, wr_ack <= 1 for exactly one cycle.
- The requester drops or changes wr_req the cycle after wr_ack.
- The block never issues two acks for one request; back-to-back requests are acked no faster than every other cycle. This is achieved by blocking a grant in the cycle wr_ack is high.
- If wr_addr >= DEPTH, the request is acked but mem_we stays 0 (write dropped).

Idle free slot: mem_we <= 0; mem_addr holds its value.

Decomposition:
- Package vga_pkg holds: H_ACTIVE, V_ACTIVE, FB_W, FB_H, DEPTH, ADDR_W, the colour_t (3-bit) typedef, and the clear FSM state enum (IDLE, CLEAR).
- One natural sub-module: vga_sync_delay, a parameterised PIPE-deep delay line for hsync/vsync.

Test Plan:
- Reset mid-frame with RESET_N=0 -> RGB=0, hsync=1, vsync=1, mem_we=0, wr_ack=0, clr_busy=0 immediately, with no clock required.
- Preload RAM addr 161 = 3'b101; drive hcount=4..7, vcount=4..7 -> mem_addr=161 at each fetch; RGB=3'b101 for 4 consecutive cycles starting 3 cycles after hcount=4.
- Hold wr_req=1 with addr 42, data 3'b110, during active video at hcount=0 -> no ack in the fetch slot; wr_ack in the next free slot with mem_we=1, mem_addr=42.
- clr_start with clr_color=3'b011 during vblank -> clr_busy high for DEPTH write cycles plus stalls; every address 0..19199 written with 3'b011; a concurrent wr_req is not acked until clr_busy=0.
- wr_req with wr_addr=19200 -> wr_ack pulses once and mem_we stays 0.
- Continuous wr_req stream over a full line -> no write ever lands on a hcount[1:0]==0 active cycle; display data is uncorrupted.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA framebuffer / VRAM arbitration slice.
// 160x120 framebuffer at 3-bit colour, each pixel shown as a 4x4 block on 640x480.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int FB_W     = H_ACTIVE / 4;
  localparam int FB_H     = V_ACTIVE / 4;
  localparam int DEPTH    = FB_W * FB_H;
  localparam int ADDR_W   = 15;
  localparam int PIPE     = 3;

  typedef logic [2:0] colour_t;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/vga_sync_delay.sv
// Fixed-depth delay line that keeps raw sync signals aligned with the RGB pipeline.
module vga_sync_delay #(
  parameter int              PIPE      = 3,
  parameter int              WIDTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [PIPE];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < PIPE; i++) begin
        stage_q[i] <= RESET_VAL;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < PIPE; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[PIPE-1];

endmodule

// File: rtl/vga_vram_arbiter.sv
// Shares a single-port synchronous-read VRAM between display fetch, a clear engine
// and a pixel writer; the display owns every 4th active cycle, the rest are free slots.
module vga_vram_arbiter
  import vga_pkg::*;
(
  input  logic              CLK_25MH,
  input  logic              RESET_N,
  input  logic [9:0]        hcount,
  input  logic [9:0]        vcount,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [2:0]        wr_data,
  output logic              wr_ack,
  input  logic              clr_start,
  input  logic [2:0]        clr_color,
  output logic              clr_busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [2:0]        mem_wdata,
  input  logic [2:0]        mem_rdata,
  output logic [2:0]        RGB,
  output logic              hsync,
  output logic              vsync
);

  localparam logic [ADDR_W-1:0] LastAddr  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] DepthAddr = ADDR_W'(DEPTH);

  logic              active, fetchSlot;
  logic [7:0]        fbRow, fbCol;
  logic [ADDR_W-1:0] fetchAddr;

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] clrCnt_q, clrCnt_d;
  colour_t           clrColour_q, clrColour_d;

  logic [ADDR_W-1:0] memAddr_q, memAddr_d;
  logic              memWe_q, memWe_d;
  colour_t           memWdata_q, memWdata_d;
  logic              wrAck_q, wrAck_d;
  logic              clrBusy_q, clrBusy_d;

  logic [1:0]        fetchPipe_q, activePipe_q;
  colour_t           hold_q, hold_d;
  colour_t           rgb_q, rgb_d;
  logic [1:0]        syncDly;

  assign active    = (hcount < 10'(H_ACTIVE)) && (vcount < 10'(V_ACTIVE));
  assign fetchSlot = active && (hcount[1:0] == 2'b00);
  assign fbRow     = vcount[9:2];
  assign fbCol     = hcount[9:2];
  // row * 160 as row * 128 + row * 32
  assign fetchAddr = (ADDR_W'(fbRow) << 7) + (ADDR_W'(fbRow) << 5) + ADDR_W'(fbCol);

  always_ff @(posedge CLK_25MH or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= IDLE;
      clrCnt_q    <= '0;
      clrColour_q <= '0;
    end else begin
      state_q     <= state_d;
      clrCnt_q    <= clrCnt_d;
      clrColour_q <= clrColour_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clrCnt_d    = clrCnt_q;
    clrColour_d = clrColour_q;
    case (state_q)
      IDLE: begin
        if (clr_start) begin
          state_d     = CLEAR;
          clrCnt_d    = '0;
          clrColour_d = clr_color;
        end
      end
      CLEAR: begin
        if (!fetchSlot) begin
          if (clrCnt_q == LastAddr) begin
            state_d  = IDLE;
            clrCnt_d = '0;
          end else begin
            clrCnt_d = clrCnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A writer grant is refused while wr_ack is high so one request never gets two acks.
  always_comb begin
    memAddr_d  = memAddr_q;
    memWe_d    = 1'b0;
    memWdata_d = memWdata_q;
    wrAck_d    = 1'b0;
    clrBusy_d  = (state_d == CLEAR);
    if (fetchSlot) begin
      memAddr_d = fetchAddr;
    end else if (state_q == CLEAR) begin
      memAddr_d  = clrCnt_q;
      memWdata_d = clrColour_q;
      memWe_d    = 1'b1;
    end else if (wr_req && !wrAck_q) begin
      wrAck_d = 1'b1;
      if (wr_addr < DepthAddr) begin
        memAddr_d  = wr_addr;
        memWdata_d = wr_data;
        memWe_d    = 1'b1;
      end
    end
  end

  always_comb begin
    rgb_d  = '0;
    hold_d = hold_q;
    if (fetchPipe_q[1]) begin
      rgb_d  = mem_rdata;
      hold_d = mem_rdata;
    end else if (activePipe_q[1]) begin
      rgb_d = hold_q;
    end
  end

  always_ff @(posedge CLK_25MH or negedge RESET_N) begin
    if (!RESET_N) begin
      memAddr_q    <= '0;
      memWe_q      <= 1'b0;
      memWdata_q   <= '0;
      wrAck_q      <= 1'b0;
      clrBusy_q    <= 1'b0;
      fetchPipe_q  <= '0;
      activePipe_q <= '0;
      hold_q       <= '0;
      rgb_q        <= '0;
    end else begin
      memAddr_q    <= memAddr_d;
      memWe_q      <= memWe_d;
      memWdata_q   <= memWdata_d;
      wrAck_q      <= wrAck_d;
      clrBusy_q    <= clrBusy_d;
      fetchPipe_q  <= {fetchPipe_q[0], fetchSlot};
      activePipe_q <= {activePipe_q[0], active};
      hold_q       <= hold_d;
      rgb_q        <= rgb_d;
    end
  end

  vga_sync_delay #(
    .PIPE      (PIPE),
    .WIDTH     (2),
    .RESET_VAL (2'b11)
  ) u_sync_delay (
    .clk_i  (CLK_25MH),
    .rst_ni (RESET_N),
    .d_i    ({hsync_in, vsync_in}),
    .q_o    (syncDly)
  );

  assign mem_addr  = memAddr_q;
  assign mem_we    = memWe_q;
  assign mem_wdata = memWdata_q;
  assign wr_ack    = wrAck_q;
  assign clr_busy  = clrBusy_q;
  assign RGB       = rgb_q;
  assign hsync     = syncDly[1];
  assign vsync     = syncDly[0];

endmodule
